// File: rtl/exception_ctrl_n.sv
// COP0 exception/interrupt controller: synchronised edge-triggered sources,
// fixed priority with preemption, and an EPC stack for nested handlers.
module exception_ctrl_n #(
  parameter int unsigned N_SRC      = 3,
  parameter int unsigned EPC_DEPTH  = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_3000,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0100
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_SRC-1:0]             exp_src,
  input  logic [31:0]                  pc_in,
  input  logic                         cop0_en,
  input  logic [31:0]                  inst,
  input  logic [31:0]                  din,
  output logic [31:0]                  dout,
  output logic                         ex_reg_write,
  output logic                         has_exp,
  output logic                         is_eret,
  output logic [31:0]                  pc_out,
  output logic [$clog2(EPC_DEPTH):0]   depth
);

  localparam int unsigned AW = $clog2(EPC_DEPTH);
  localparam int unsigned DW = AW + 1;
  localparam int unsigned SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0] sync1_q, sync2_q, prev_q, rise;
  logic [2:0]       warm_q;
  logic [N_SRC-1:0] pending_q, pending_d, mask_q, mask_d;
  logic             ie_q, ie_d, err_q, err_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic [31:0]      epc_q [EPC_DEPTH];
  logic [SW-1:0]    src_q [EPC_DEPTH];

  logic [4:0]    rs, rd;
  logic [5:0]    funct;
  logic          op_mfc0, op_mtc0, op_eret, wr_en;
  logic          empty, full, preempt, take, do_eret;
  logic [AW-1:0] top_idx, push_idx;
  logic [31:0]   top_epc, vector, rdata;
  logic [SW-1:0] top_src, cand_idx;
  logic          cand_vld;
  logic          unused_inst;

  assign rs          = inst[25:21];
  assign rd          = inst[15:11];
  assign funct       = inst[5:0];
  assign unused_inst = ^{inst[31:26], inst[20:16], inst[10:6]};

  assign op_mfc0 = cop0_en && (rs == 5'b00000);
  assign op_mtc0 = cop0_en && (rs == 5'b00100);
  assign op_eret = cop0_en && (rs == 5'b10000) && (funct == 6'b011000);

  assign empty    = (depth_q == '0);
  assign full     = (depth_q == DW'(EPC_DEPTH));
  assign top_idx  = AW'(depth_q - DW'(1));
  assign push_idx = depth_q[AW-1:0];
  assign top_src  = src_q[top_idx];
  assign top_epc  = empty ? '0 : epc_q[top_idx];

  always_comb begin
    cand_vld = 1'b0;
    cand_idx = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (pending_q[i] && mask_q[i]) begin
        cand_vld = 1'b1;
        cand_idx = SW'(i);
      end
    end
  end

  // A taken exception squashes the current instruction, so its COP0 side effects are dropped.
  assign preempt = empty || (cand_idx > top_src);
  assign take    = ie_q && cand_vld && preempt && !full && !op_eret;
  assign do_eret = op_eret && !empty;
  assign wr_en   = op_mtc0 && !take;
  assign vector  = VEC_BASE + 32'(cand_idx) * VEC_STRIDE;

  assign has_exp      = take;
  assign is_eret      = do_eret;
  assign pc_out       = do_eret ? top_epc : (take ? vector : '0);
  assign ex_reg_write = op_mfc0 && !take && !reset;
  assign dout         = ex_reg_write ? rdata : '0;
  assign depth        = depth_q;

  always_comb begin
    rdata = '0;
    case (rd)
      5'd12: begin
        rdata[0]         = ie_q;
        rdata[8+:N_SRC]  = mask_q;
      end
      5'd13: begin
        rdata[31]        = err_q;
        rdata[8+:N_SRC]  = pending_q;
        if (!empty) rdata[2+:SW] = top_src;
      end
      5'd14:   rdata = top_epc;
      default: rdata = '0;
    endcase
  end

  // Edges are ignored until the synchroniser has refilled after reset,
  // so a line already high at release is not mistaken for a request.
  assign rise = sync2_q & ~prev_q & {N_SRC{warm_q[2]}};

  always_comb begin
    pending_d = pending_q;
    mask_d    = mask_q;
    ie_d      = ie_q;
    err_d     = err_q;
    depth_d   = depth_q;
    if (wr_en && rd == 5'd12) begin
      ie_d   = din[0];
      mask_d = din[8+:N_SRC];
    end
    if (wr_en && rd == 5'd13) begin
      pending_d = pending_d & ~din[8+:N_SRC];
      if (din[31]) err_d = 1'b0;
    end
    if (take) begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        if (cand_idx == SW'(i)) pending_d[i] = 1'b0;
      end
      depth_d = depth_q + DW'(1);
    end
    if (do_eret) depth_d = depth_q - DW'(1);
    if (op_eret && empty) err_d = 1'b1;
    pending_d = pending_d | rise;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      warm_q    <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      ie_q      <= 1'b0;
      err_q     <= 1'b0;
      depth_q   <= '0;
    end else begin
      sync1_q   <= exp_src;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      warm_q    <= {warm_q[1:0], 1'b1};
      pending_q <= pending_d;
      mask_q    <= mask_d;
      ie_q      <= ie_d;
      err_q     <= err_d;
      depth_q   <= depth_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < EPC_DEPTH; i++) begin
        epc_q[i] <= '0;
        src_q[i] <= '0;
      end
    end else if (take) begin
      epc_q[push_idx] <= pc_in;
      src_q[push_idx] <= cand_idx;
    end else if (wr_en && rd == 5'd14 && !empty) begin
      epc_q[top_idx] <= din;
    end
  end

endmodule
